// File: rtl/grad_norm_pwl.sv
// grad_norm_pwl: programmable piecewise-linear gradient-cost normaliser.
//   y = base[s] + (slope[s] * (x - bp[s])) >>> FRAC, saturated to [0, 2^OUT_W-1]
// Three-stage pipeline (segment select, multiply, add/saturate) with a
// valid/ready handshake and a global clock enable. The segment table is
// runtime-writable through the cfg_* port.
// Optional build macro: GRAD_NORM_PWL_ROUND_EN selects round-half-up for the
// final FRAC shift instead of floor.
module grad_norm_pwl #(
  parameter int unsigned IN_W     = 12,
  parameter int unsigned OUT_W    = 11,
  parameter int unsigned SEG_LOG2 = 4,
  parameter int unsigned SLOPE_W  = 12,
  parameter int unsigned FRAC     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clken,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_sat,
  input  logic                cfg_we,
  input  logic [SEG_LOG2-1:0] cfg_addr,
  input  logic [IN_W-1:0]     cfg_bp,
  input  logic [OUT_W-1:0]    cfg_base,
  input  logic [SLOPE_W-1:0]  cfg_slope
);

  localparam int unsigned SEG    = 1 << SEG_LOG2;
  localparam int unsigned PROD_W = SLOPE_W + IN_W + 1;
  // Two guard bits above the product cover the base addition and rounding.
  localparam int unsigned SUM_W  = PROD_W + 2;

  // ---------------------------------------------------------------------------
  // Segment table
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]    bp_q    [SEG];
  logic [OUT_W-1:0]   base_q  [SEG];
  logic [SLOPE_W-1:0] slope_q [SEG];

  // Table storage: evenly spaced breakpoints at reset, written independently of clken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SEG; i++) begin
        bp_q[i]    <= IN_W'(i << (IN_W - SEG_LOG2));
        base_q[i]  <= '0;
        slope_q[i] <= '0;
      end
    end else if (cfg_we) begin
      bp_q[cfg_addr]    <= cfg_bp;
      base_q[cfg_addr]  <= cfg_base;
      slope_q[cfg_addr] <= cfg_slope;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic adv;
  logic out_valid_q;

  // Whole pipeline advances together; bubbles travel with the data.
  always_comb begin
    adv      = clken & (~out_valid_q | out_ready);
    in_ready = adv;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: segment select
  // ---------------------------------------------------------------------------
  logic [SEG_LOG2-1:0] seg_sel;
  logic [IN_W-1:0]     seg_bp;
  logic [IN_W-1:0]     seg_d;

  // Highest segment whose breakpoint is <= x; segment 0 always matches at 0.
  // Scanning upward and overwriting keeps the rule correct for unsorted tables.
  always_comb begin
    seg_sel = '0;
    for (int unsigned i = 1; i < SEG; i++) begin
      if (in_data >= bp_q[i]) seg_sel = SEG_LOG2'(i);
    end
    seg_bp = (seg_sel == '0) ? '0 : bp_q[seg_sel];
    seg_d  = in_data - seg_bp;
  end

  logic               s1_valid_q;
  logic [IN_W-1:0]    s1_d_q;
  logic [OUT_W-1:0]   s1_base_q;
  logic [SLOPE_W-1:0] s1_slope_q;

  // Stage 1 register: offset and the coefficients are captured with the sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_d_q     <= '0;
      s1_base_q  <= '0;
      s1_slope_q <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_d_q     <= seg_d;
        s1_base_q  <= base_q[seg_sel];
        s1_slope_q <= slope_q[seg_sel];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: full-precision signed multiply
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] s2_prod_d;

  // Offset is non-negative, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    s2_prod_d = $signed(s1_slope_q) * $signed({1'b0, s1_d_q});
  end

  logic                     s2_valid_q;
  logic signed [PROD_W-1:0] s2_prod_q;
  logic [OUT_W-1:0]         s2_base_q;

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_base_q  <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_q <= s2_prod_d;
        s2_base_q <= s1_base_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: scale, add base, saturate
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] prod_ext;
  logic signed [SUM_W-1:0] prod_sh;
  logic signed [SUM_W-1:0] sum;
  logic                    sum_neg;
  logic                    sum_over;
  logic [OUT_W-1:0]        out_data_d;
  logic                    out_sat_d;

`ifdef GRAD_NORM_PWL_ROUND_EN
  localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(1) << (FRAC - 1);
`endif

  // Shift the product down to integer units, add the base and clamp.
  always_comb begin
    prod_ext = {{(SUM_W - PROD_W){s2_prod_q[PROD_W-1]}}, s2_prod_q};
`ifdef GRAD_NORM_PWL_ROUND_EN
    prod_ext = prod_ext + RND_HALF;
`endif
    prod_sh  = prod_ext >>> FRAC;
    sum      = prod_sh + $signed({{(SUM_W - OUT_W){1'b0}}, s2_base_q});
    sum_neg  = sum[SUM_W-1];
    sum_over = ~sum_neg & (|sum[SUM_W-2:OUT_W]);
    out_data_d = sum[OUT_W-1:0];
    out_sat_d  = 1'b0;
    if (sum_neg) begin
      out_data_d = '0;
      out_sat_d  = 1'b1;
    end else if (sum_over) begin
      out_data_d = '1;
      out_sat_d  = 1'b1;
    end
  end

  logic [OUT_W-1:0] out_data_q;
  logic             out_sat_q;

  // Output register: data only reloads on a real sample so it holds through bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end

  // Output port drive.
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_sat   = out_sat_q;
  end

endmodule

// File: tb/tb_grad_norm_pwl.sv
// Scoreboard bench for grad_norm_pwl: the driver pushes expected results from
// an arithmetic reference model at acceptance time; a monitor pops and
// compares on every output transfer.
module tb_grad_norm_pwl;

  localparam int IN_W     = 12;
  localparam int OUT_W    = 11;
  localparam int SEG_LOG2 = 4;
  localparam int SLOPE_W  = 12;
  localparam int FRAC     = 8;
  localparam int SEG      = 1 << SEG_LOG2;
  localparam int OMAX     = (1 << OUT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                clken;
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_sat;
  logic                cfg_we;
  logic [SEG_LOG2-1:0] cfg_addr;
  logic [IN_W-1:0]     cfg_bp;
  logic [OUT_W-1:0]    cfg_base;
  logic [SLOPE_W-1:0]  cfg_slope;

  grad_norm_pwl #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SEG_LOG2(SEG_LOG2), .SLOPE_W(SLOPE_W), .FRAC(FRAC)
  ) dut (
    .clk(clk), .rst(rst), .clken(clken),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bp(cfg_bp), .cfg_base(cfg_base),
    .cfg_slope(cfg_slope)
  );

  typedef struct { int data; int sat; } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;

  int m_bp[SEG];
  int m_base[SEG];
  int m_slope[SEG];

  bit last_acc, last_rdy;
  bit dir_en = 0;
  int dir_d, dir_s;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < SEG; i++) begin
      m_bp[i] = i * (1 << (IN_W - SEG_LOG2));
      m_base[i] = 0;
      m_slope[i] = 0;
    end
  endfunction

  // y = base + floor((slope*(x-bp) [+ half]) / 2^FRAC), clamped to [0, OMAX]
  function automatic exp_t model(input int x);
    int s = 0;
    int d;
    longint p, t, sh, sm;
    exp_t r;
    for (int i = 1; i < SEG; i++) if (x >= m_bp[i]) s = i;
    d = x - ((s == 0) ? 0 : m_bp[s]);
    p = longint'(m_slope[s]) * longint'(d);
    t = p;
`ifdef GRAD_NORM_PWL_ROUND_EN
    t = p + (longint'(1) << (FRAC - 1));
`endif
    if (t >= 0) sh = t / (longint'(1) << FRAC);
    else sh = -((-t + (longint'(1) << FRAC) - 1) / (longint'(1) << FRAC));
    sm = longint'(m_base[s]) + sh;
    if (sm < 0) r = '{0, 1};
    else if (sm > OMAX) r = '{OMAX, 1};
    else r = '{int'(sm), 0};
    return r;
  endfunction

  // One clock: called at a falling edge with inputs already set.
  task automatic tick();
    exp_t e;
    #1;
    last_rdy = in_ready;
    last_acc = rst && in_valid && in_ready;
    if (last_acc) begin
      if (dir_en) e = '{dir_d, dir_s};
      else e = model(int'(in_data));
      q.push_back(e);
    end
    if (rst && cfg_we) begin
      m_bp[cfg_addr]    = int'(cfg_bp);
      m_base[cfg_addr]  = int'(cfg_base);
      m_slope[cfg_addr] = int'($signed(cfg_slope));
    end
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int bp, input int base, input int slope);
    cfg_we = 1; cfg_addr = SEG_LOG2'(a); cfg_bp = IN_W'(bp);
    cfg_base = OUT_W'(base); cfg_slope = SLOPE_W'(slope);
    tick();
    cfg_we = 0;
  endtask

  // Hold a sample until accepted; dir selects a fixed expectation over the model.
  task automatic send(input int x, input bit dir, input int ed, input int es);
    in_valid = 1; in_data = IN_W'(x);
    dir_en = dir; dir_d = ed; dir_s = es;
    for (int k = 0; k < 50; k++) begin
      tick();
      cfg_we = 0;
      if (last_acc) break;
    end
    in_valid = 0; dir_en = 0;
    chk("send_accept", int'(last_acc), 1);
  endtask

  task automatic drain(input int budget);
    in_valid = 0; cfg_we = 0; out_ready = 1; clken = 1;
    for (int k = 0; k < budget && q.size() != 0; k++) tick();
    tick();
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: compare on each output transfer, away from the clock edge.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (rst && clken && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: got %0d expected none (t=%0t)", out_data, $time);
      end else begin
        e = q.pop_front();
        n_pop++;
        chk("out_data", int'(out_data), e.data);
        chk("out_sat", int'(out_sat), e.sat);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, pop0;
    int xs[6];
    rst = 0; clken = 1; in_valid = 0; in_data = '0; out_ready = 1;
    cfg_we = 0; cfg_addr = '0; cfg_bp = '0; cfg_base = '0; cfg_slope = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    rst = 1;
    tick();

    // 1: default table, latency of three edges
    send(100, 1, 0, 0);
    chk("t1_in_ready", int'(last_rdy), 1);
    chk("t1_lat1", int'(out_valid), 0);
    tick();
    chk("t1_lat2", int'(out_valid), 0);
    chk("t1_in_ready2", int'(last_rdy), 1);
    tick();
    chk("t1_lat3", int'(out_valid), 1);
    drain(20);

    // 2: two segments, back-to-back
    wr(0, 0, 1023, -256);
    wr(1, 256, 767, -128);
    send(10, 1, 1013, 0);
    send(300, 1, 745, 0);
    tick();
    chk("t2_first_valid", int'(out_valid), 1);
    tick();
    chk("t2_second_valid", int'(out_valid), 1);
    drain(20);

    // 3: clamping both ways
    wr(0, 0, 100, -256);
    send(200, 1, 0, 1);
    wr(0, 0, 2000, 256);
    send(100, 1, OMAX, 1);
    drain(20);

    // 4: backpressure and clken freeze
    wr(0, 0, 300, 77);
    wr(3, 900, 1500, -300);
    xs = '{5, 260, 950, 1200, 700, 4000};
    out_ready = 0; n_acc = 0; pop0 = n_pop;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_data = IN_W'(xs[n_acc]);
      tick();
      if (last_acc) n_acc++;
    end
    chk("t4_accepted", n_acc, 3);
    chk("t4_in_ready_low", int'(last_rdy), 0);
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      clken = 0;
      #1;
      chk("t4_hold_in_ready", int'(in_ready), 0);
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_data", int'(out_data), (q.size() != 0) ? q[0].data : -1);
      tick();
    end
    clken = 1;
    for (int k = n_acc; k < 6; k++) send(xs[k], 0, 0, 0);
    drain(30);
    chk("t4_popped", n_pop - pop0, 6);

    // 5: rounding of a negative half
`ifdef GRAD_NORM_PWL_ROUND_EN
    wr(0, 0, 500, -1); send(128, 1, 500, 0);
`else
    wr(0, 0, 500, -1); send(128, 1, 499, 0);
`endif
    drain(20);

    // 6: write coincident with acceptance, then reset mid-stream
    wr(0, 0, 1023, -256);
    cfg_we = 1; cfg_addr = '0; cfg_bp = '0; cfg_base = 11'd1023; cfg_slope = SLOPE_W'(-128);
    send(10, 1, 1013, 0);
    send(10, 1, 1018, 0);
    send(40, 0, 0, 0);
    send(1000, 0, 0, 0);
    tick();
    chk("t6_pre_rst_valid", int'(out_valid), 1);
    #5 rst = 0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    q.delete();
    model_reset();
    cfg_we = 1; cfg_addr = 4'd2; cfg_bp = 12'd512; cfg_base = 11'd999; cfg_slope = '0;
    @(negedge clk);
    tick(); tick();
    cfg_we = 0;
    rst = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_no_stale", int'(out_valid), 0);
    end
    send(600, 1, 0, 0);
    drain(20);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clken     = ($urandom_range(0, 9) != 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = SEG_LOG2'($urandom_range(0, SEG - 1));
      cfg_bp    = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      cfg_base  = OUT_W'($urandom_range(0, OMAX));
      cfg_slope = SLOPE_W'($urandom_range(0, (1 << SLOPE_W) - 1));
      tick();
    end
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
